// File: rtl/FPALL_pkg.sv
// Shared types and helpers for the FP normalizer scheduling slice.
// Holds the op format and scheduler state enums, plus the leading-zero counters
// used by the normalizer datapath.
package FPALL_pkg;

    localparam int FRAC_W = 28;
    localparam int HALF_W = 14;
    localparam int CNT_W  = 5;

    typedef enum logic {
        FMT_FP32 = 1'b0,
        FMT_FP16 = 1'b1
    } fp_fmt_e;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } norm_sched_state_e;

    // Leading zeros of a full-width fraction; an all-zero input reports 28.
    function automatic logic [4:0] lzc28(input logic [27:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd28;
        found = 1'b0;
        for (int i = 27; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(27 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Leading zeros of one half-width lane; an all-zero lane reports 14.
    function automatic logic [4:0] lzc14(input logic [13:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd14;
        found = 1'b0;
        for (int i = 13; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(13 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/norm_sched_normalizer.sv
// Combinational fraction normalizer.
// FP32 mode treats the 28-bit input as one fraction; FP16 mode treats it as two
// independent 14-bit lanes. Each lane is shifted left until its MSB is set and
// the shift amount is reported. The clock port exists only so the block can be
// dropped into a pipelined variant without changing its interface.
module norm_sched_normalizer
    import FPALL_pkg::*;
(
    input  logic        clk,
    input  fp_fmt_e     fmt,
    input  logic [27:0] x,
    output logic [27:0] r,
    output logic [4:0]  count_h,
    output logic [4:0]  count_l
);

    logic        unused_clk;
    logic [4:0]  lz_full;
    logic [4:0]  lz_hi;
    logic [4:0]  lz_lo;
    logic [13:0] hi_norm;
    logic [13:0] lo_norm;

    assign unused_clk = clk;

    // Count and shift both the full-width and the per-lane views, then pick by format.
    always_comb begin
        lz_full = lzc28(x);
        lz_hi   = lzc14(x[27:14]);
        lz_lo   = lzc14(x[13:0]);
        hi_norm = x[27:14] << lz_hi;
        lo_norm = x[13:0] << lz_lo;
        r       = x << lz_full;
        count_h = 5'd0;
        count_l = lz_full;
        if (fmt == FMT_FP16) begin
            r       = {hi_norm, lo_norm};
            count_h = lz_hi;
            count_l = lz_lo;
        end
    end

endmodule

// File: rtl/norm_sched.sv
// Normalizer issue scheduler.
// FP32 ops issue straight through. A lone FP16 op is parked so it can share a
// normalizer beat with the next FP16 op; it issues alone on flush, when an FP32
// op arrives behind it (keeping acceptance order), or after PAIR_TIMEOUT cycles.
// Results sit in an output register with a valid/ready handshake.
module norm_sched
    import FPALL_pkg::*;
#(
    parameter int PAIR_TIMEOUT = 4,
    parameter int TAG_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  fp_fmt_e          in_fmt,
    input  logic [27:0]      in_frac,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output fp_fmt_e          out_fmt,
    output logic [27:0]      out_r,
    output logic [4:0]       out_count_h,
    output logic [4:0]       out_count_l,
    output logic             out_vld_h,
    output logic             out_vld_l,
    output logic [TAG_W-1:0] out_tag_h,
    output logic [TAG_W-1:0] out_tag_l
);

    localparam logic [3:0] CNT_LAST = 4'(PAIR_TIMEOUT - 1);

    norm_sched_state_e state;
    logic [3:0]        wait_cnt;
    logic [13:0]       parked_frac;
    logic [TAG_W-1:0]  parked_tag;

    logic              slot_free;
    logic              is_fp16;
    logic              ready_c;
    logic              accept;
    logic              park;
    logic              issue_single;
    logic              issue_pair;
    logic              issue_solo;
    logic              issue;

    fp_fmt_e           iss_fmt;
    logic [27:0]       iss_x;
    logic              iss_vld_h;
    logic              iss_vld_l;
    logic [TAG_W-1:0]  iss_tag_h;
    logic [TAG_W-1:0]  iss_tag_l;

    logic [27:0]       norm_r;
    logic [4:0]        norm_ch;
    logic [4:0]        norm_cl;

    assign slot_free = !out_valid || out_ready;
    assign is_fp16   = (in_fmt == FMT_FP16);
    assign in_ready  = ready_c;
    assign accept    = in_valid && ready_c;
    assign issue     = issue_single || issue_pair || issue_solo;

    // Input acceptance: an FP16 can always be parked from IDLE, anything that issues needs the slot.
    always_comb begin
        ready_c = 1'b0;
        if (!rst) begin
            if (state == IDLE) begin
                ready_c = is_fp16 || slot_free;
            end else begin
                ready_c = is_fp16 && !flush && slot_free;
            end
        end
    end

    // Decide this cycle's action; pairing takes priority over any solo trigger.
    always_comb begin
        park         = 1'b0;
        issue_single = 1'b0;
        issue_pair   = 1'b0;
        issue_solo   = 1'b0;
        if (state == IDLE) begin
            park         = accept && is_fp16;
            issue_single = accept && !is_fp16;
        end else begin
            issue_pair = accept;
            issue_solo = !accept && slot_free &&
                         (flush || (in_valid && !is_fp16) || (wait_cnt == CNT_LAST));
        end
    end

    // Build the normalizer operand and lane metadata for whatever issues.
    always_comb begin
        iss_fmt   = FMT_FP32;
        iss_x     = in_frac;
        iss_vld_h = 1'b0;
        iss_vld_l = 1'b1;
        iss_tag_h = '0;
        iss_tag_l = in_tag;
        if (state == HOLD) begin
            iss_fmt   = FMT_FP16;
            iss_vld_h = 1'b1;
            iss_tag_h = parked_tag;
            iss_vld_l = issue_pair;
            iss_x     = {parked_frac, issue_pair ? in_frac[13:0] : 14'h0};
            iss_tag_l = issue_pair ? in_tag : '0;
        end
    end

    norm_sched_normalizer normalizer (
        .clk     (clk),
        .fmt     (iss_fmt),
        .x       (iss_x),
        .r       (norm_r),
        .count_h (norm_ch),
        .count_l (norm_cl)
    );

    // Scheduler state, parked op, wait counter and the output result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            parked_frac <= 14'h0;
            parked_tag  <= '0;
            out_valid   <= 1'b0;
            out_fmt     <= FMT_FP32;
            out_r       <= 28'h0;
            out_count_h <= 5'd0;
            out_count_l <= 5'd0;
            out_vld_h   <= 1'b0;
            out_vld_l   <= 1'b0;
            out_tag_h   <= '0;
            out_tag_l   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (park) begin
                        parked_frac <= in_frac[13:0];
                        parked_tag  <= in_tag;
                        wait_cnt    <= 4'd0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (issue_pair || issue_solo) begin
                        wait_cnt <= 4'd0;
                        state    <= IDLE;
                    end else if (wait_cnt != CNT_LAST) begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (issue) begin
                out_valid   <= 1'b1;
                out_fmt     <= iss_fmt;
                out_r       <= norm_r;
                out_count_h <= norm_ch;
                out_count_l <= iss_vld_l ? norm_cl : 5'd0;
                out_vld_h   <= iss_vld_h;
                out_vld_l   <= iss_vld_l;
                out_tag_h   <= iss_tag_h;
                out_tag_l   <= iss_tag_l;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/norm_sched.md
NORM_SCHED -- requirements
Module: norm_sched

Interface
REQ-001 Parameter PAIR_TIMEOUT, 4, number of cycles a lone FP16 op waits for a partner (legal range 1..15).
REQ-002 Parameter TAG_W, 4, width of the per-op tag.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  op offered.
REQ-007 in_ready  output  1  op accepted when in_valid and in_ready are both high.
REQ-008 in_fmt  input  fp_fmt_e  FP32 or FP16 op.
REQ-009 in_frac  input  28  FP32 fraction, or FP16 fraction in bits [13:0] (bits [27:14] ignored).
REQ-010 in_tag  input  TAG_W  op identifier, returned with the result.
REQ-011 flush  input  1  force issue of a parked FP16 op without a partner.
REQ-012 out_valid, out_ready  output/input  1 each  result handshake.
REQ-013 out_fmt  output  fp_fmt_e  issued format.
REQ-014 out_r  output  28  normalized fraction.
REQ-015 out_count_h, out_count_l  output  5 each  normalizer LZC results.
REQ-016 out_vld_h, out_vld_l  output  1 each  lane carries a real op.
REQ-017 out_tag_h, out_tag_l  output  TAG_W each  lane tags.

Function
REQ-018 States: IDLE (nothing parked) and HOLD (one FP16 op parked); a wait counter of 4 bits.
REQ-019 Issue slot free: out_valid==0 or out_ready==1.
REQ-020 in_ready: slot free, except in HOLD, where in_ready=0 when in_fmt==FP32 or flush==1. In IDLE with in_fmt==FP16, in_ready=1 regardless of slot.
REQ-021 IDLE, FP32 accepted: issue X=in_frac, fmt FP32. Result appears on out_* the next cycle: out_vld_l=1, out_tag_l=in_tag, out_vld_h=0, out_count_h=0.
REQ-022 IDLE, FP16 accepted: park the frac and tag, go to HOLD with counter=0, no issue.
REQ-023 HOLD, FP16 accepted: issue X={parked_frac, in_frac[13:0]} in FP16 mode with both lane valids set, tag_h=parked and tag_l=in_tag, then go to IDLE.
REQ-024 HOLD, solo issue when the slot is free and any of these holds: flush, in_valid with in_fmt==FP32, or counter==PAIR_TIMEOUT-1. Solo issue uses X={parked_frac, 14'h0}, out_vld_l=0, out_tag_l=0, out_count_l masked to 0, then go to IDLE.
REQ-025 HOLD with no issue: counter increments, saturating at PAIR_TIMEOUT-1.
REQ-026 Timeout and an accepted FP16 in the same cycle: pairing wins.
REQ-027 Flush and an FP16 in the same cycle: flush wins and the FP16 is not accepted.
REQ-028 Ordering: results leave in acceptance order. A parked FP16 always issues before a later FP32.
REQ-029 Output register: loaded on issue, held stable while out_valid && !out_ready, cleared to out_valid=0 when consumed with no new issue.
REQ-030 Throughput: one issue per cycle with out_ready held high.

Reset
REQ-031 While rst=1: state=IDLE, counter=0, parked op discarded, out_valid=0, all out_* data and tags=0, in_ready=0.
REQ-032 Reset mid-operation drops any parked or unconsumed result without emitting it.

Structure
REQ-033 fp_fmt_e and new norm_sched_state_e {IDLE, HOLD} live in FPALL_pkg.
REQ-034 One sub-module instance, normalizer, combinational between the issue mux and the output register; its clk is tied to clk.

Verification
REQ-035 FP32: in_frac=28'h0100000, tag 3 -> next cycle out_r=28'h8000000, out_count_l=7, out_vld_l=1, tag_l=3, out_vld_h=0.
REQ-036 FP16 pair: 14'h0100 (tag 1) then 14'h0100 (tag 2) on consecutive cycles -> single beat one cycle after the second accept. Hi lane: out_r[27:14]=14'h2000, count_h=5, tag_h=1. Lo lane: matches the normalizer model, tag_l=2.
REQ-037 Timeout: lone FP16 tag 5 with PAIR_TIMEOUT=4 and no input -> solo beat, out_vld_h=1, out_vld_l=0, out_valid rising 4 cycles after accept.
REQ-038 FP32 behind a parked FP16: in_ready=0 for one cycle, FP16 solo beat first, FP32 beat next.
REQ-039 Backpressure: out_ready=0 for 3 cycles with a result pending -> out_* stable, in_ready=0 for FP32, FP16 still parkable in IDLE.
REQ-040 Reset asserted while in HOLD -> no result emitted, out_valid=0, state IDLE on the first cycle after deassertion.
